// File: rtl/braille_rotor_ctrl.sv
// Turns one accepted Braille cell into parallel step/dir pulse trains for the rotors of one display cell.
// Optional: define BRAILLE8_EN to add a fourth rotor that presents dots 7/8.
module braille_rotor_ctrl #(
    parameter int STEPS_PER_FACE = 50,
    parameter int STEP_DIV       = 4,
    parameter int SETTLE_CYC     = 8,
`ifdef BRAILLE8_EN
    localparam int NR            = 4
`else
    localparam int NR            = 3
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cell_valid,
    output logic            cell_ready,
    input  logic [7:0]      cell_data,
    output logic [NR-1:0]   step,
    output logic [NR-1:0]   dir,
    output logic            busy,
    output logic            done,
    output logic [2*NR-1:0] pos
);
    localparam int RW = $clog2(2*STEPS_PER_FACE+1);
    localparam int DW = $clog2(STEP_DIV);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [RW-1:0] ONE_FACE = RW'(STEPS_PER_FACE);
    localparam logic [RW-1:0] TWO_FACE = RW'(2*STEPS_PER_FACE);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MOVE, S_SETTLE, S_DONE} state_t;

    state_t          r_state;
    logic [7:0]      r_data;
    logic [RW-1:0]   r_rem [NR];
    logic [DW-1:0]   r_div;
    logic [SW-1:0]   r_settle;
    logic [NR-1:0]   r_step;
    logic [NR-1:0]   r_dir;
    logic [2*NR-1:0] r_pos;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;

    logic [2*NR-1:0] w_target;
    logic [RW-1:0]   w_steps [NR];
    logic [NR-1:0]   w_dir;
    logic [1:0]      w_delta;
    logic            w_any_move;
    logic            w_last_tick;
    logic            w_tick;

    // Face index is {right dot, left dot}; the shortest way round is chosen from the modular distance.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_target    = '0;
        w_steps     = '{default: '0};
        w_dir       = '0;
        w_delta     = '0;
        w_any_move  = 1'b0;
        w_last_tick = 1'b1;
        for (int r = 0; r < NR; r++) begin
            if (r == 3) w_target[2*r +: 2] = r_data[7:6];
            else        w_target[2*r +: 2] = {r_data[r+3], r_data[r]};
            w_delta    = w_target[2*r +: 2] - r_pos[2*r +: 2];
            w_steps[r] = (w_delta == 2'd2) ? TWO_FACE :
                         (w_delta == 2'd0) ? '0 : ONE_FACE;
            w_dir[r]   = (w_delta == 2'd1) || (w_delta == 2'd2);
            if (w_delta != 2'd0)      w_any_move  = 1'b1;
            if (r_rem[r] > RW'(1))    w_last_tick = 1'b0;
        end
    end

    assign w_tick = (r_div == DW'(STEP_DIV-1));

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_data   <= '0;
            r_div    <= '0;
            r_settle <= '0;
            r_step   <= '0;
            r_dir    <= '0;
            r_pos    <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            // NOTE: the step counters are a handful of flops, not a RAM, so resetting them is cheap and safe.
            for (int r = 0; r < NR; r++) r_rem[r] <= '0;
        end else begin
            r_step <= '0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cell_valid) begin
                        r_data  <= cell_data;
                        r_state <= S_LOAD;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_div <= '0;
                    r_dir <= w_dir;
                    for (int r = 0; r < NR; r++) r_rem[r] <= w_steps[r];
                    if (w_any_move) begin
                        r_state <= S_MOVE;
                    end else begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_MOVE: begin
                    if (w_tick) begin
                        r_div <= '0;
                        for (int r = 0; r < NR; r++) begin
                            if (r_rem[r] != '0) begin
                                r_step[r] <= 1'b1;
                                r_rem[r]  <= r_rem[r] - RW'(1);
                                if (r_rem[r] == RW'(1)) r_pos[2*r +: 2] <= w_target[2*r +: 2];
                            end
                        end
                        if (w_last_tick) begin
                            r_state  <= S_SETTLE;
                            r_settle <= '0;
                        end
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_settle == SW'(SETTLE_CYC-1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cell_ready = r_ready;
    assign step       = r_step;
    assign dir        = r_dir;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pos        = r_pos;

endmodule

// File: tb/tb_braille_rotor_ctrl.sv
// Scoreboard bench for braille_rotor_ctrl: driver pushes model predictions, a negedge monitor checks each completed cell.
module tb_braille_rotor_ctrl;
`ifdef BRAILLE8_EN
    localparam int NR = 4;
`else
    localparam int NR = 3;
`endif
    localparam int SPF    = 50;
    localparam int SDIV   = 4;
    localparam int SETTLE = 8;

    typedef struct packed {
        logic [3:0][7:0] steps;
        logic [3:0]      dir;
        logic [7:0]      pos;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            cell_valid;
    logic            cell_ready;
    logic [7:0]      cell_data;
    logic [NR-1:0]   step;
    logic [NR-1:0]   dir;
    logic            busy;
    logic            done;
    logic [2*NR-1:0] pos;

    braille_rotor_ctrl #(.STEPS_PER_FACE(SPF), .STEP_DIV(SDIV), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .reset(reset), .cell_valid(cell_valid), .cell_ready(cell_ready),
        .cell_data(cell_data), .step(step), .dir(dir), .busy(busy), .done(done), .pos(pos)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   faces [4];
    exp_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int target_face(input logic [7:0] d, input int r);
        if (r == 3) return int'(d[6]) + 2*int'(d[7]);
        return int'(d[r]) + 2*int'(d[r+3]);
    endfunction

    // Predicts the outcome of one cell from the current model faces and advances the model.
    function automatic exp_t predict(input logic [7:0] d);
        exp_t e;
        e = '0;
        for (int r = 0; r < NR; r++) begin
            int t, dl;
            t  = target_face(d, r);
            dl = (t - faces[r] + 4) % 4;
            e.steps[r] = 8'((dl == 3) ? SPF : dl * SPF);
            e.dir[r]   = (dl == 1 || dl == 2);
            faces[r]   = t;
            e.pos[2*r +: 2] = 2'(t);
        end
        return e;
    endfunction

    function automatic bit would_move(input logic [7:0] d);
        for (int r = 0; r < NR; r++)
            if (target_face(d, r) != faces[r]) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- monitor ----------------
    int mcyc = 0, start_cyc = 0, first_pulse = -1, last_pulse = -1, sp_err = 0, inv_err = 0;
    int cnt [4];
    int lastp [4];
    bit in_txn = 0, prev_busy = 0, prev_done = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            mcyc++;
            if (cell_ready !== (!busy && !done)) inv_err++;
            if (step != '0 && !busy) inv_err++;
            if (done && prev_done) inv_err++;
            if (reset) begin
                in_txn = 0;
            end else begin
                if (busy && !prev_busy) begin
                    in_txn = 1; start_cyc = mcyc; first_pulse = -1; last_pulse = -1; sp_err = 0;
                    for (int r = 0; r < 4; r++) begin cnt[r] = 0; lastp[r] = -1; end
                end
                for (int r = 0; r < NR; r++) begin
                    if (step[r]) begin
                        if (!in_txn) inv_err++;
                        cnt[r]++;
                        if (lastp[r] >= 0 && mcyc - lastp[r] != SDIV) sp_err++;
                        lastp[r] = mcyc;
                        if (first_pulse < 0) first_pulse = mcyc;
                        last_pulse = mcyc;
                    end
                end
                if (done) begin
                    if (!in_txn || sb_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_done: got done with %0d queued at %0t", sb_q.size(), $time);
                    end else begin
                        exp_t e;
                        bit   any;
                        e   = sb_q.pop_front();
                        any = 0;
                        for (int r = 0; r < NR; r++) begin
                            check($sformatf("steps_r%0d", r), cnt[r], 32'(e.steps[r]));
                            if (e.steps[r] != 0) begin
                                any = 1;
                                check($sformatf("dir_r%0d", r), 32'(dir[r]), 32'(e.dir[r]));
                            end
                        end
                        check("pos", 32'(pos), 32'(e.pos));
                        check("pulse_spacing_errors", sp_err, 0);
                        if (any) begin
                            check("first_pulse_latency", first_pulse - start_cyc, 1 + SDIV);
                            check("settle_to_done", mcyc - last_pulse, SETTLE);
                        end else begin
                            check("zero_move_latency", mcyc - start_cyc, 1);
                        end
                    end
                    in_txn = 0;
                end
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_done();
        int guard = 0;
        while (guard < 2000) begin
            @(negedge clk);
            if (done) return;
            guard++;
        end
        check("done_timeout", 32'(done), 1);
    endtask

    task automatic send(input logic [7:0] d, input bit hold, input bit wait_for_done);
        int guard = 0;
        @(negedge clk);
        while (!cell_ready && guard < 2000) begin @(negedge clk); guard++; end
        if (!cell_ready) begin check("ready_timeout", 32'(cell_ready), 1); return; end
        cell_valid = 1'b1;
        cell_data  = d;
        @(posedge clk);
        sb_q.push_back(predict(d));
        #1;
        if (hold) begin
            guard = 0;
            while (guard < 2000) begin
                @(negedge clk);
                if (done) break;
                cell_data = 8'($urandom);
                guard++;
            end
            cell_valid = 1'b0;
            if (!done) check("hold_done_timeout", 32'(done), 1);
        end else begin
            cell_valid = 1'b0;
            if (wait_for_done) wait_done();
        end
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got %0d tests", tests);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] d;
        for (int r = 0; r < 4; r++) faces[r] = 0;
        reset = 1'b1; cell_valid = 1'b0; cell_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(cell_ready), 1);
        check("rst_step",  32'(step), 0);
        check("rst_dir",   32'(dir), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_pos",   32'(pos), 0);
        @(posedge clk); #2 reset = 1'b0;

        send(8'h00, 0, 1);
        send(8'h01, 0, 1);
        send(8'h08, 0, 1);
        send(8'h00, 0, 1);
        send(8'h09, 0, 1);
        send(8'h00, 0, 1);
        send(8'h3F, 0, 1);
        send(8'h00, 0, 1);
        send(8'hC0, 0, 1);
        send(8'h2A, 1, 0);
        for (int i = 0; i < 12; i++) send(8'($urandom), 1'($urandom_range(0, 1)), 1);

        // Abort a move part-way with reset.
        d = 8'($urandom);
        while (!would_move(d)) d = 8'($urandom);
        send(d, 0, 0);
        repeat (30) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_step",  32'(step), 0);
        check("midrst_pos",   32'(pos), 0);
        check("midrst_ready", 32'(cell_ready), 1);
        check("midrst_busy",  32'(busy), 0);
        sb_q.delete();
        for (int r = 0; r < 4; r++) faces[r] = 0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        send(8'h01, 0, 1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        check("invariant_errors", inv_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/braille_rotor_ctrl.md
Name: braille_rotor_ctrl

Overview:
- Downstream of the Braille storage stage. Consumes one 8-bit Braille cell pattern per handshake and turns it into step/dir pulse trains for the stepper-driven rotors of one display cell.
- Each rotor presents one row (two dots) and has 4 faces.
- The block tracks the current face of each rotor, computes the shortest move to the target face, steps all rotors in parallel, then waits a settle time and reports done.

Parameters:
- STEPS_PER_FACE, 50, motor steps between adjacent faces (200-step motor / 4 faces); must be >=1.
- STEP_DIV, 4, clk cycles per step tick; must be >=2.
- SETTLE_CYC, 8, clk cycles held in SETTLE after the last step pulse; must be >=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cell_valid  in  1  cell_data is valid.
- cell_ready  out  1  block can accept a cell (high only in IDLE).
- cell_data  in  8  Braille pattern: bit0..bit7 = dots 1..8.
- step  out  NR  one-cycle step pulse per rotor. NR = 3, or 4 with BRAILLE8_EN.
- dir  out  NR  per-rotor direction: 1 = forward, 0 = reverse.
- busy  out  1  high in LOAD, MOVE and SETTLE.
- done  out  1  one-cycle pulse when a cell update completes.
- pos  out  2*NR  current face of each rotor; rotor r occupies bits [2r+1:2r].

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately:
  - state = IDLE, cell_ready = 1;
  - step, dir, busy, done = 0;
  - pos = 0 (blank face); divider and step counters = 0.
- Reset mid-operation aborts the move. No further pulses are issued and pos returns to 0. Realigning the rotors mechanically is the system's job.
- Face mapping: rotor r uses dots (r+1) and (r+4), i.e. rotor0 = dots 1/4, rotor1 = dots 2/5, rotor2 = dots 3/6. Face index = {right dot, left dot}. Example: dot1 only gives face 1; dot4 only gives face 2.
- Handshake: a cell is accepted on a rising edge with cell_valid && cell_ready. cell_data is captured at that edge. Changes on cell_data/cell_valid while not ready are ignored.
- FSM:
  - IDLE -> LOAD on accept.
  - LOAD (1 cycle), per rotor: delta = (target - pos) mod 4.
    - delta 0: 0 steps.
    - delta 1: forward, STEPS_PER_FACE steps.
    - delta 2: forward, 2*STEPS_PER_FACE steps.
    - delta 3: reverse, STEPS_PER_FACE steps.
    - dir is registered here and held until the next LOAD.
    - The divider is cleared.
    - If all deltas are 0, go to DONE; otherwise go to MOVE.
  - MOVE: the divider counts 0..STEP_DIV-1. A tick occurs on the cycle it equals STEP_DIV-1.
    - On a tick, every rotor with remaining > 0 pulses step for exactly one cycle and decrements remaining.
    - When a rotor's remaining reaches 0, its pos field loads its target.
    - When all remaining = 0 after a tick, go to SETTLE.
    - Consecutive pulses on one rotor are exactly STEP_DIV cycles apart. The first pulse occurs STEP_DIV cycles after entering MOVE.
  - SETTLE: counts SETTLE_CYC cycles with no step pulses, then goes to DONE.
  - DONE (1 cycle): done = 1, busy = 0. Next state is IDLE; cell_ready = 1 again in the following cycle.
- Counter width: remaining counter width = clog2(2*STEPS_PER_FACE+1).
- Simultaneous events: a rotor's final step and its pos update happen on the same edge. Rotors finish independently; the FSM waits for the last one.
- Bits 7:6 of cell_data are ignored unless BRAILLE8_EN is defined.

Optional Feature:
- Macro: BRAILLE8_EN.
- Defined: NR = 4. Rotor3 presents dots 7/8, face = {bit7, bit6}. step, dir and pos widen to 4/4/8 bits.
- Undefined: NR = 3. Bits 7:6 have no effect.

Test Plan:
- Reset, then send 0x00 -> done pulses for one cycle, no step pulses ever, pos stays 0, cell_ready returns high.
- From reset, send 0x01 -> dir[0] = 1; exactly 50 pulses on step[0], 4 cycles apart; step[2:1] silent; pos = 6'b000001; done after 8 settle cycles.
- Then send 0x08 -> rotor0 face 1->2, forward 50 steps. Then send 0x00 -> rotor0 face 2->0 (delta 2), forward 100 steps. From blank, send 0x09 -> dir[0] = 0, 50 reverse steps, pos[1:0] = 3.
- Send 0x3F from blank -> all three rotors reverse 50 steps in parallel with coincident pulses; pos = 6'b111111.
- Hold cell_valid with changing data during MOVE -> cell_ready = 0 and busy = 1 throughout; only the first cell is applied. Assert reset mid-MOVE -> step stops immediately, pos = 0, cell_ready = 1.
- With BRAILLE8_EN, send 0xC0 -> only rotor3 moves: reverse 50 steps, pos[7:6] = 3.
